branch_zero_seq: RTL and testbench
==================================

BRANCH_ZERO_SEQ -- requirements
Module: branch_zero_seq

Interface
REQ-001 SHALL have parameter CHUNK, default 8, giving the bits OR-reduced per scan cycle; legal values are 1, 2, 4, 8, 16 and 32.
REQ-002 SHALL have parameter EARLY_EXIT, default 1; 1 ends the scan on the first nonzero chunk, 0 always scans the full word.
REQ-003 SHALL have CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have START, input, 1 bit: request to evaluate a branch, accepted only while READY=1.
REQ-006 SHALL have ABORT, input, 1 bit: synchronous cancel of an evaluation in progress.
REQ-007 SHALL have A, input, 32 bits: operand rs1.
REQ-008 SHALL have B, input, 32 bits: operand rs2.
REQ-009 SHALL have FUNCT3, input, 3 bits: branch type; 000 = BEQ, 001 = BNE, any other code is illegal.
REQ-010 SHALL have READY, output, 1 bit: high while in IDLE.
REQ-011 SHALL have BUSY, output, 1 bit: high while in SCAN.
REQ-012 SHALL have DONE, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have ZERO, output, 1 bit: result flag, 1 when A equals B.
REQ-014 SHALL have TAKEN, output, 1 bit: branch decision.
REQ-015 SHALL have ILLEGAL, output, 1 bit: FUNCT3 was unsupported.

Function
REQ-016 SHALL implement a three-state FSM with states IDLE, SCAN and FIN; READY is high only in IDLE, BUSY only in SCAN, and DONE only in FIN.
REQ-017 SHALL, in IDLE with START=1 and ABORT=0, register D = A XOR B and register FUNCT3, clear the accumulator and set chunk index 0.
REQ-018 SHALL, on the same accepting edge as REQ-017, go to SCAN if FUNCT3 is legal, or go to FIN with ILLEGAL=1 if FUNCT3 is illegal.
REQ-019 SHALL ignore START while READY=0, with no effect on the latched operands or the results.
REQ-020 SHALL, on each SCAN edge, OR-reduce D[idx*CHUNK +: CHUNK] into the accumulator, scanning from the LSB chunk upward, then increment idx.
REQ-021 SHALL leave SCAN for FIN on the edge that processes the last chunk (idx = 32/CHUNK-1), or earlier on a nonzero chunk when EARLY_EXIT=1.
REQ-022 SHALL hold ZERO = NOT accumulator in FIN.
REQ-023 SHALL set TAKEN = ZERO for BEQ and TAKEN = NOT ZERO for BNE.
REQ-024 SHALL force TAKEN=0 and ZERO=0 when ILLEGAL=1.
REQ-025 SHALL remain in FIN for exactly one cycle and then return to IDLE unconditionally; START is not accepted in FIN.
REQ-026 SHALL keep ZERO, TAKEN and ILLEGAL stable from FIN until the next accepted START, which clears them.
REQ-027 SHALL set latency from the accepting edge k so that DONE is high in cycle k+n+1, with n = number of chunks scanned (1 ≤ n ≤ 32/CHUNK); an illegal FUNCT3 gives DONE in cycle k+1.
REQ-028 SHALL give the worst case with CHUNK=8 as DONE in cycle k+5, and with CHUNK=32 as DONE in cycle k+2.
REQ-029 SHALL, on ABORT=1 in SCAN or FIN, go to IDLE on the next edge with no DONE pulse and ZERO, TAKEN and ILLEGAL cleared.
REQ-030 SHALL give ABORT priority over START, chunk completion and FIN in the same cycle; ABORT in IDLE has no effect other than blocking START.
REQ-031 SHALL treat a nonzero last chunk with EARLY_EXIT=1 identically to a normal last-chunk exit, with no extra cycle.

Reset
REQ-032 SHALL, while RST_N=0 and independent of CLK, force state IDLE and READY=1.
REQ-033 SHALL, while RST_N=0 and independent of CLK, force BUSY=0, DONE=0, ZERO=0, TAKEN=0 and ILLEGAL=0.
REQ-034 SHALL, while RST_N=0 and independent of CLK, force D=0, the accumulator to 0 and idx=0.
REQ-035 SHALL abandon any evaluation in progress when reset is asserted mid-scan, with no DONE pulse.
REQ-036 SHALL allow the first START to be accepted on the first rising edge after RST_N deasserts.

Verification
REQ-037 SHALL cover: CHUNK=8, A=B=0x12345678, FUNCT3=000, START at edge 0 -> BUSY for 4 cycles, DONE in cycle 5, ZERO=1, TAKEN=1.
REQ-038 SHALL cover: A=0x00000001, B=0, FUNCT3=001, EARLY_EXIT=1 -> DONE in cycle 2, ZERO=0, TAKEN=1; the same stimulus with EARLY_EXIT=0 -> DONE in cycle 5.
REQ-039 SHALL cover: A=0x80000000, B=0, FUNCT3=000 -> 4 scan cycles, ZERO=0, TAKEN=0 (last-chunk boundary).
REQ-040 SHALL cover: FUNCT3=100 -> DONE in cycle 1, ILLEGAL=1, TAKEN=0, ZERO=0, BUSY never high.
REQ-041 SHALL cover: ABORT at the 2nd SCAN cycle together with a new START -> no DONE pulse, IDLE on the next edge, and START then accepted one cycle later.
REQ-042 SHALL cover: RST_N pulsed low between clock edges mid-scan -> all outputs zero and READY=1 immediately, and a fresh BEQ with equal operands completes normally afterwards.

Source files
------------

// File: rtl/branch_zero_seq.sv
// Multi-cycle BEQ/BNE evaluator: XORs the operands once, then OR-reduces the
// difference CHUNK bits per cycle from the LSB upward to decide equality.
module branch_zero_seq #(
  parameter int CHUNK      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic        ABORT,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  FUNCT3,
  output logic        READY,
  output logic        BUSY,
  output logic        DONE,
  output logic        ZERO,
  output logic        TAKEN,
  output logic        ILLEGAL
);
  localparam int NCH = 32 / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FIN} state_t;

  state_t r_state, w_next;

  logic [31:0]   r_d;
  logic          r_bne;
  logic          r_acc;
  logic [IW-1:0] r_idx;
  logic          r_zero, r_taken, r_illegal;

  logic [NCH-1:0][CHUNK-1:0] w_chunks;
  logic          w_legal, w_accept, w_last, w_acc_nx, w_scan_end;

  assign w_chunks   = r_d;
  assign w_legal    = (FUNCT3[2:1] == 2'b00);
  assign w_accept   = (r_state == S_IDLE) && START && !ABORT;
  assign w_last     = (r_idx == IW'(NCH - 1));
  assign w_acc_nx   = r_acc | (|w_chunks[r_idx]);
  // Exit on the last chunk, or on the first nonzero chunk when early exit is on.
  assign w_scan_end = (r_state == S_SCAN) && !ABORT &&
                      (w_last || (EARLY_EXIT && w_acc_nx));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_legal ? S_SCAN : S_FIN;
      S_SCAN: begin
        if (ABORT)           w_next = S_IDLE;
        else if (w_scan_end) w_next = S_FIN;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_d       <= '0;
      r_bne     <= 1'b0;
      r_acc     <= 1'b0;
      r_idx     <= '0;
      r_zero    <= 1'b0;
      r_taken   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_d       <= A ^ B;
      r_bne     <= FUNCT3[0];
      r_acc     <= 1'b0;
      r_idx     <= '0;
      r_zero    <= 1'b0;
      r_taken   <= 1'b0;
      r_illegal <= ~w_legal;
    end else if (ABORT && (r_state != S_IDLE)) begin
      r_zero    <= 1'b0;
      r_taken   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (r_state == S_SCAN) begin
      r_acc <= w_acc_nx;
      r_idx <= r_idx + 1'b1;
      if (w_scan_end) begin
        r_zero  <= ~w_acc_nx;
        r_taken <= r_bne ? w_acc_nx : ~w_acc_nx;
      end
    end
  end

  assign READY   = (r_state == S_IDLE);
  assign BUSY    = (r_state == S_SCAN);
  assign DONE    = (r_state == S_FIN);
  assign ZERO    = r_zero;
  assign TAKEN   = r_taken;
  assign ILLEGAL = r_illegal;
endmodule

// File: tb/tb_branch_zero_seq.sv
// Drives an early-exit and a full-scan instance with shared stimulus and checks
// both against a transaction-level countdown model every cycle.
module tb_branch_zero_seq;
  localparam int CHUNK = 8;
  localparam int NCH   = 32 / CHUNK;

  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  logic START = 1'b0, ABORT = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic [2:0]  FUNCT3 = '0;
  // index 1: EARLY_EXIT=1, index 0: EARLY_EXIT=0
  logic [1:0] o_rdy, o_busy, o_done, o_zero, o_taken, o_ill;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  branch_zero_seq #(.CHUNK(CHUNK), .EARLY_EXIT(1'b1)) u_ee (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT), .A(A), .B(B),
    .FUNCT3(FUNCT3), .READY(o_rdy[1]), .BUSY(o_busy[1]), .DONE(o_done[1]),
    .ZERO(o_zero[1]), .TAKEN(o_taken[1]), .ILLEGAL(o_ill[1]));

  branch_zero_seq #(.CHUNK(CHUNK), .EARLY_EXIT(1'b0)) u_full (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT), .A(A), .B(B),
    .FUNCT3(FUNCT3), .READY(o_rdy[0]), .BUSY(o_busy[0]), .DONE(o_done[0]),
    .ZERO(o_zero[0]), .TAKEN(o_taken[0]), .ILLEGAL(o_ill[0]));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Chunks examined before the decision is known.
  function automatic int nscan(input logic [31:0] d, input bit ee);
    longint mask = (64'd1 << CHUNK) - 1;
    if (!ee) return NCH;
    for (int i = 0; i < NCH; i++)
      if (((longint'(d) >> (i * CHUNK)) & mask) != 0) return i + 1;
    return NCH;
  endfunction

  // rem: -1 idle, >0 cycles of scanning left, 0 completion cycle
  int rem[2] = '{-1, -1};
  bit pz[2], pt[2], pi[2], vz[2], vt[2], vi[2];

  always @(posedge CLK) begin
    if (RST_N) begin
      for (int k = 0; k < 2; k++) begin
        if (rem[k] == -1) begin
          if (START && !ABORT) begin
            vz[k] = 0; vt[k] = 0; vi[k] = 0;
            if (FUNCT3 > 3'd1) begin
              pz[k] = 0; pt[k] = 0; pi[k] = 1;
              rem[k] = 0;
              vi[k] = 1;
            end else begin
              pz[k] = (A == B);
              pt[k] = (FUNCT3 == 3'd0) ? (A == B) : (A != B);
              pi[k] = 0;
              rem[k] = nscan(A ^ B, k == 1);
            end
          end
        end else if (ABORT) begin
          rem[k] = -1; vz[k] = 0; vt[k] = 0; vi[k] = 0;
        end else if (rem[k] == 0) begin
          rem[k] = -1;
        end else begin
          rem[k]--;
          if (rem[k] == 0) begin vz[k] = pz[k]; vt[k] = pt[k]; vi[k] = pi[k]; end
        end
      end
    end
  end

  always @(negedge RST_N) begin
    for (int k = 0; k < 2; k++) begin
      rem[k] = -1; vz[k] = 0; vt[k] = 0; vi[k] = 0;
    end
  end

  always @(negedge CLK) begin
    if (RST_N) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("ready[%0d]", k), int'(o_rdy[k]),   int'(rem[k] == -1));
        chk($sformatf("busy[%0d]", k),  int'(o_busy[k]),  int'(rem[k] > 0));
        chk($sformatf("done[%0d]", k),  int'(o_done[k]),  int'(rem[k] == 0));
        chk($sformatf("zero[%0d]", k),  int'(o_zero[k]),  int'(vz[k]));
        chk($sformatf("taken[%0d]", k), int'(o_taken[k]), int'(vt[k]));
        chk($sformatf("illegal[%0d]", k), int'(o_ill[k]), int'(vi[k]));
      end
    end
  end

  // Called a little after an edge with both instances idle; the start is
  // accepted on the next edge. Cycle numbers count the accepting edge as cycle 0.
  task automatic run_dir(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input int c1, input int c0,
                         input int ez, input int et, input int ei, input int nbusy);
    int l1 = -1, l0 = -1, nb = 0;
    A = a; B = b; FUNCT3 = f3; START = 1'b1;
    @(posedge CLK);
    #2 START = 1'b0;
    for (int i = 0; i < 12 && (l1 < 0 || l0 < 0); i++) begin
      @(negedge CLK);
      if (o_busy[1]) nb++;
      if (o_done[1] && l1 < 0) begin
        l1 = i + 1;
        chk({nm, " zero"},    int'(o_zero[1]),  ez);
        chk({nm, " taken"},   int'(o_taken[1]), et);
        chk({nm, " illegal"}, int'(o_ill[1]),   ei);
      end
      if (o_done[0] && l0 < 0) begin
        l0 = i + 1;
        chk({nm, " zero full"},  int'(o_zero[0]),  ez);
        chk({nm, " taken full"}, int'(o_taken[0]), et);
      end
    end
    chk({nm, " done cycle early-exit"}, l1, c1);
    chk({nm, " done cycle full-scan"},  l0, c0);
    if (nbusy >= 0) chk({nm, " busy cycles"}, nb, nbusy);
    @(posedge CLK);
    #2;
  endtask

  task automatic chk_reset_outs(input string nm);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s ready[%0d]", nm, k), int'(o_rdy[k]), 1);
      chk($sformatf("%s outs[%0d]", nm, k),
          int'({o_busy[k], o_done[k], o_zero[k], o_taken[k], o_ill[k]}), 0);
    end
  endtask

  initial begin
    #1 RST_N = 1'b0;
    #1 chk_reset_outs("por");
    #1 RST_N = 1'b1;
    // first START lands on the first edge after reset release
    run_dir("beq_equal",  32'h12345678, 32'h12345678, 3'b000, 5, 5, 1, 1, 0, 4);
    run_dir("bne_lsb",    32'h00000001, 32'h0,        3'b001, 2, 5, 0, 1, 0, -1);
    run_dir("beq_msb",    32'h80000000, 32'h0,        3'b000, 5, 5, 0, 0, 0, 4);
    run_dir("illegal",    32'h5,        32'h5,        3'b100, 1, 1, 0, 0, 1, 0);

    // abort in the 2nd scan cycle together with START
    A = 32'h0; B = 32'h0; FUNCT3 = 3'b000; START = 1'b1;
    @(posedge CLK);
    #2 START = 1'b0;
    @(posedge CLK);
    #2 START = 1'b1; ABORT = 1'b1;
    @(posedge CLK);
    #2 ABORT = 1'b0;
    #1 chk("abort ready", int'(o_rdy), 3);
    chk("abort done", int'(o_done), 0);
    @(posedge CLK);
    #2 START = 1'b0;
    #1 chk("restart busy", int'(o_busy), 3);
    repeat (8) @(posedge CLK);
    #2 chk("restart zero", int'(o_zero), 3);

    // reset pulse between edges while scanning
    A = 32'hCAFE0000; B = 32'hCAFE0000; FUNCT3 = 3'b000; START = 1'b1;
    @(posedge CLK);
    #2 START = 1'b0;
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1 chk_reset_outs("midscan reset");
    #1 RST_N = 1'b1;
    @(posedge CLK);
    #2;
    run_dir("after_reset", 32'hA5A5A5A5, 32'hA5A5A5A5, 3'b000, 5, 5, 1, 1, 0, 4);

    for (int c = 0; c < 1500; c++) begin
      int r;
      A = $urandom;
      case ($urandom_range(0, 3))
        0:       B = A;
        1:       B = A ^ (32'h1 << $urandom_range(0, 31));
        default: B = $urandom;
      endcase
      r = $urandom_range(0, 9);
      FUNCT3 = (r < 4) ? 3'b000 : (r < 8) ? 3'b001 : 3'($urandom_range(2, 7));
      START = ($urandom_range(0, 1) == 1);
      ABORT = ($urandom_range(0, 19) == 0);
      @(posedge CLK);
      #2;
    end
    START = 1'b0; ABORT = 1'b0;
    repeat (10) @(posedge CLK);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
